// File: rtl/six_step_commutation_sequencer.sv
// Six-step commutation sequencer for the PMSM_v4 motor model.
// Runs an align -> open-loop ramp -> run start-up, in either rotation
// direction, and produces the registered {a,b,c} phase pattern together with
// sector, sector strobe, running flag and electrical revolution count.
// Optional feature macro: DEAD_TIME_EN. When defined, every sector advance
// shows DEAD_CYCLES all-off cycles before the new pattern.
module six_step_commutation_sequencer #(
  parameter int PERIOD_W    = 16,
  parameter int STEP_W      = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] align_ticks,
  input  logic [PERIOD_W-1:0] start_period,
  input  logic [PERIOD_W-1:0] target_period,
  input  logic [STEP_W-1:0]   ramp_step,
  output logic [2:0]          V_phase,
  output logic [2:0]          sector,
  output logic                sector_strobe,
  output logic                running,
  output logic [15:0]         rev_count
);

`ifdef DEAD_TIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif
  localparam bit                USE_DEAD = DEAD_EN && (DEAD_CYCLES > 0);
  localparam logic [PERIOD_W-1:0] ONE    = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] DEAD_P = PERIOD_W'(DEAD_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RAMP, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] counter_q, counter_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic [PERIOD_W-1:0] dead_left_q, dead_left_d;
  logic [2:0]          v_phase_q, v_phase_d;
  logic [2:0]          sector_q, sector_d;
  logic                strobe_q, strobe_d;
  logic                running_q, running_d;
  logic [15:0]         rev_q, rev_d;

  // Phase pattern for each sector; out-of-range codes are all-off.
  function automatic logic [2:0] sector_pattern(input logic [2:0] s);
    case (s)
      3'd0:    sector_pattern = 3'b100;
      3'd1:    sector_pattern = 3'b110;
      3'd2:    sector_pattern = 3'b010;
      3'd3:    sector_pattern = 3'b011;
      3'd4:    sector_pattern = 3'b001;
      3'd5:    sector_pattern = 3'b101;
      default: sector_pattern = 3'b000;
    endcase
  endfunction

  // A period of zero behaves as a one-cycle sector.
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] step_ext;
  logic [PERIOD_W-1:0] ramped_period;
  logic                boundary;
  logic                align_done;
  logic                wrap;
  logic [2:0]          sector_next;

  assign eff_period = (cur_period_q == '0) ? ONE : cur_period_q;
  assign step_ext   = PERIOD_W'(ramp_step);
  // max(cur - step, target) without ever letting the subtraction underflow.
  assign ramped_period = (cur_period_q <= target_period)                  ? target_period :
                         ((cur_period_q - target_period) > step_ext)     ? cur_period_q - step_ext :
                                                                           target_period;
  assign boundary    = ((state_q == S_RAMP) || (state_q == S_RUN)) &&
                       (counter_q >= eff_period - ONE);
  assign align_done  = (align_ticks == '0) || (counter_q >= align_ticks - ONE);
  // dir is only consumed on a boundary cycle, so a mid-sector change never
  // shortens or skips a sector.
  assign wrap        = dir ? (sector_q == 3'd0) : (sector_q == 3'd5);
  assign sector_next = dir ? ((sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1)
                           : ((sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1);

  // State and registered outputs; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational processes.
    if (rst) begin
      state_q      <= S_IDLE;
      counter_q    <= '0;
      cur_period_q <= '0;
      dead_left_q  <= '0;
      v_phase_q    <= 3'b000;
      sector_q     <= 3'd0;
      strobe_q     <= 1'b0;
      running_q    <= 1'b0;
      rev_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      cur_period_q <= cur_period_d;
      dead_left_q  <= dead_left_d;
      v_phase_q    <= v_phase_d;
      sector_q     <= sector_d;
      strobe_q     <= strobe_d;
      running_q    <= running_d;
      rev_q        <= rev_d;
    end
  end

  // Next-state logic: enable low always wins and parks the FSM in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = (align_ticks == '0) ? S_RAMP : S_ALIGN;
        S_ALIGN: if (align_done) state_d = S_RAMP;
        S_RAMP:  if (boundary && (ramped_period == target_period)) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values: counter, period, sector, pattern, status.
  always_comb begin
    counter_d    = counter_q;
    cur_period_d = cur_period_q;
    dead_left_d  = dead_left_q;
    v_phase_d    = v_phase_q;
    sector_d     = sector_q;
    strobe_d     = 1'b0;
    rev_d        = rev_q;
    running_d    = (state_d == S_RUN);
    if (!enable) begin
      // Stop: outputs off, sector and revolution count are kept.
      counter_d   = '0;
      v_phase_d   = 3'b000;
      dead_left_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          counter_d    = '0;
          sector_d     = 3'd0;
          v_phase_d    = sector_pattern(3'd0);
          cur_period_d = start_period;
          dead_left_d  = '0;
        end
        S_ALIGN: begin
          if (align_done) begin
            counter_d    = '0;
            cur_period_d = start_period;
          end else begin
            counter_d = counter_q + ONE;
          end
        end
        S_RAMP, S_RUN: begin
          if (boundary) begin
            counter_d    = '0;
            sector_d     = sector_next;
            strobe_d     = 1'b1;
            cur_period_d = (state_q == S_RAMP) ? ramped_period : target_period;
            if (wrap) rev_d = rev_q + 16'd1;
            if (USE_DEAD) begin
              v_phase_d   = 3'b000;
              dead_left_d = DEAD_P - ONE;
            end else begin
              v_phase_d = sector_pattern(sector_next);
            end
          end else begin
            counter_d = counter_q + ONE;
            if (dead_left_q != '0) begin
              v_phase_d   = 3'b000;
              dead_left_d = dead_left_q - ONE;
            end else begin
              v_phase_d = sector_pattern(sector_q);
            end
          end
        end
        default: counter_d = '0;
      endcase
    end
  end

  assign V_phase       = v_phase_q;
  assign sector        = sector_q;
  assign sector_strobe = strobe_q;
  assign running       = running_q;
  assign rev_count     = rev_q;

endmodule
